// File: rtl/ready_valid_fifo_pkg.sv
// ---------------------------------------------------------------------------
// ready_valid_pkg
//   Shared definitions for the ready/valid FIFO and anything that inspects it.
//   - ptr_width(depth): width of a wrap-bit pointer for a FIFO of 'depth'
//     entries ($clog2(depth) index bits plus one wrap bit).
//   - fifo_state_t: occupancy classification derived from the two pointers.
// ---------------------------------------------------------------------------
package ready_valid_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } fifo_state_t;

  // Index bits plus one wrap bit, so FULL and EMPTY are distinguishable
  // without a separate occupancy counter.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // True when depth is a power of two and at least 2.
  function automatic bit depth_is_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/ready_valid_fifo_if.sv
// ---------------------------------------------------------------------------
// ready_valid_i
//   Single-direction ready/valid channel.
//   Signals:
//     data  [DATA_WIDTH-1:0] : payload, driven by the master
//     valid                  : payload present, driven by the master
//     ready                  : sink can accept, driven by the slave
//   Modports:
//     m : master (drives data/valid, observes ready)
//     s : slave  (observes data/valid, drives ready)
// ---------------------------------------------------------------------------
interface ready_valid_i #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport m (
    output data,
    output valid,
    input  ready
  );

  modport s (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/ready_valid_fifo_ptr.sv
// ---------------------------------------------------------------------------
// ready_valid_fifo_ptr
//   One FIFO pointer register with wrap bit. Increments by one when i_en is
//   high at a rising clock edge, wrapping naturally modulo 2**PW.
//   Ports:
//     clk   : clock
//     rst   : asynchronous active-high reset, clears the pointer to 0
//     i_en  : advance the pointer this cycle
//     o_ptr : current pointer value [PW-1:0] (MSB is the wrap bit)
// ---------------------------------------------------------------------------
module ready_valid_fifo_ptr #(
  parameter int PW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [PW-1:0] o_ptr
);

  logic [PW-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + PW'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/ready_valid_fifo.sv
// ---------------------------------------------------------------------------
// ready_valid_fifo
//   First-word-fall-through FIFO with ready/valid on both sides. Intended to
//   sit in front of a ready/valid duplicator: in.ready is a function of
//   registered pointer state (and reset) only, so the consumer's ready never
//   reaches the producer combinationally.
//
//   Parameters:
//     DEPTH      : entries, power of two and >= 2 (checked at elaboration)
//     DATA_WIDTH : payload width, must match the interface width
//   Ports:
//     clk        : clock, all state updates on the rising edge
//     rst        : asynchronous active-high reset; discards all stored beats
//     in         : producer side (slave modport: data/valid in, ready out)
//     out        : consumer side (master modport: data/valid out, ready in)
//     fill_level : stored entry count, 0..DEPTH
//                  (only when READY_VALID_FIFO_FILL_LEVEL_EN is defined)
//
//   Optional feature macro: READY_VALID_FIFO_FILL_LEVEL_EN
// ---------------------------------------------------------------------------
module ready_valid_fifo
  import ready_valid_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  ready_valid_i.s                     in,
  ready_valid_i.m                     out
`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
  ,
  output logic [ptr_width(DEPTH)-1:0] fill_level
`endif
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  // -------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // -------------------------------------------------------------------------
  if (!depth_is_legal(DEPTH)) begin : g_bad_depth
    $error("ready_valid_fifo: DEPTH must be a power of two and >= 2");
  end

  if ($bits(in.data) != DATA_WIDTH || $bits(out.data) != DATA_WIDTH) begin : g_bad_width
    $error("ready_valid_fifo: interface data width differs from DATA_WIDTH");
  end

  // -------------------------------------------------------------------------
  // Pointers and occupancy
  // -------------------------------------------------------------------------
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;
  fifo_state_t   w_state;

  assign w_wr_idx = w_wr_ptr[AW-1:0];
  assign w_rd_idx = w_rd_ptr[AW-1:0];

  // Occupancy is purely a view of the pointers; no separate counter exists
  // that could drift out of step with them.
  always_comb begin
    w_state = PARTIAL;
    if (w_wr_ptr == w_rd_ptr) begin
      w_state = EMPTY;
    end else if ((w_wr_idx == w_rd_idx) && (w_wr_ptr[AW] != w_rd_ptr[AW])) begin
      w_state = FULL;
    end
  end

  assign w_full  = (w_state == FULL);
  assign w_empty = (w_state == EMPTY);

  // rst is folded in so a beat presented during reset can never be taken,
  // including in the cycle in which reset is asserted asynchronously.
  assign in.ready  = !w_full && !rst;
  assign out.valid = !w_empty;

  assign w_push = in.valid && in.ready;
  assign w_pop  = out.valid && out.ready;

  ready_valid_fifo_ptr #(
    .PW (PW)
  ) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_push),
    .o_ptr (w_wr_ptr)
  );

  ready_valid_fifo_ptr #(
    .PW (PW)
  ) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .i_en  (w_pop),
    .o_ptr (w_rd_ptr)
  );

  // -------------------------------------------------------------------------
  // Storage
  // -------------------------------------------------------------------------
  // Contents are deliberately not reset: after reset the FIFO is EMPTY, so
  // out.data is don't-care until a new beat has been written.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= in.data;
    end
  end

  // Fall-through read: the head entry is presented as soon as it is written.
  // The entry at rd_ptr cannot be overwritten while it is stored (a write to
  // that index requires the FIFO to be non-full relative to it), so the data
  // is stable for as long as out.valid is high and no pop occurs.
  assign out.data = r_mem[w_rd_idx];

`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
  // Modular difference of the wrap-bit pointers gives 0..DEPTH directly.
  assign fill_level = w_wr_ptr - w_rd_ptr;
`endif

endmodule

// File: tb/tb_ready_valid_fifo.sv
// ---------------------------------------------------------------------------
// tb_ready_valid_fifo
//   Self-checking bench for ready_valid_fifo (DEPTH=4, DATA_WIDTH=8).
//   A queue-based reference model tracks the stored beats; each scenario task
//   compares the DUT against it and against fixed expected values.
// ---------------------------------------------------------------------------
module tb_ready_valid_fifo;
  import ready_valid_pkg::*;

  localparam int DEPTH = 4;
  localparam int DW    = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ready_valid_i #(.DATA_WIDTH(DW)) in_if ();
  ready_valid_i #(.DATA_WIDTH(DW)) out_if ();

`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
  logic [ptr_width(DEPTH)-1:0] fill_level;
`endif

  ready_valid_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in_if),
    .out        (out_if)
`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
    ,
    .fill_level (fill_level)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;

  logic [DW-1:0] model_q [$];

  // Classification of what the DUT shows on its handshake outputs.
  function automatic fifo_state_t observed_state();
    if (!out_if.valid) return EMPTY;
    if (!in_if.ready)  return FULL;
    return PARTIAL;
  endfunction

  function automatic fifo_state_t model_state();
    if (model_q.size() == 0)     return EMPTY;
    if (model_q.size() == DEPTH) return FULL;
    return PARTIAL;
  endfunction

  // Advance one clock edge and update the model from the handshake rules:
  // a push happens when valid and the FIFO has room, a pop when something
  // is stored and the consumer is ready. Inputs must be settled on entry.
  task automatic tick();
    bit            push;
    bit            pop;
    logic [DW-1:0] din;
    push = in_if.valid && !rst && (model_q.size() < DEPTH);
    pop  = out_if.ready && !rst && (model_q.size() > 0);
    din  = in_if.data;
    @(posedge clk);
    #1;
    if (rst) begin
      model_q.delete();
    end else begin
      if (pop) begin
        $display("t=%0t pop  0x%02h", $time, model_q[0]);
        void'(model_q.pop_front());
      end
      if (push) begin
        $display("t=%0t push 0x%02h", $time, din);
        model_q.push_back(din);
        n_push++;
      end
    end
  endtask

  task automatic test_reset();
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    rst          = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_if.valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_out_valid cyc%0d got=%b exp=0", i, out_if.valid);
      end
      n_checks++;
      if (in_if.ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_in_ready cyc%0d got=%b exp=0", i, in_if.ready);
      end
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (in_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_in_ready got=%b exp=1", in_if.ready);
    end
    n_checks++;
    if (out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_out_valid got=%b exp=0", out_if.valid);
    end
  endtask

  task automatic test_single_beat();
    in_if.valid  = 1'b1;
    in_if.data   = 8'hA5;
    out_if.ready = 1'b1;
    n_checks++;
    if (out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_no_bypass got=%b exp=0", out_if.valid);
    end
    tick();
    in_if.valid = 1'b0;
    n_checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_out got valid=%b data=0x%02h exp valid=1 data=0xa5",
               out_if.valid, out_if.data);
    end
    tick();
    n_checks++;
    if (out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drained got=%b exp=0", out_if.valid);
    end
  endtask

  task automatic test_fill_stall();
    out_if.ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = DW'(i);
      n_checks++;
      if (in_if.ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready_before_push%0d got=%b exp=1", i, in_if.ready);
      end
      tick();
    end
    in_if.data = 8'h05;
    n_checks++;
    if (in_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full_ready got=%b exp=0", in_if.ready);
    end
`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
    n_checks++;
    if (fill_level !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_level_full got=%0d exp=4", fill_level);
    end
`endif
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1 || out_if.data !== 8'h01) begin
        n_fail++;
        $display("FAIL stall_hold cyc%0d got ready=%b valid=%b data=0x%02h exp 0/1/0x01",
                 i, in_if.ready, out_if.valid, out_if.data);
      end
      n_checks++;
      if (model_q.size() !== DEPTH) begin
        n_fail++;
        $display("FAIL stall_model_size got=%0d exp=%0d", model_q.size(), DEPTH);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [DW-1:0] got [$];
    logic [DW-1:0] exp_seq [5];
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    out_if.ready = 1'b1;
    in_if.valid  = 1'b1;
    in_if.data   = 8'h05;
    n_checks++;
    if (in_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_refuse got=%b exp=0", in_if.ready);
    end
    if (out_if.valid) got.push_back(out_if.data);
    tick();
    n_checks++;
    if (in_if.ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_ready_rise got=%b exp=1", in_if.ready);
    end
    if (out_if.valid) got.push_back(out_if.data);
    tick();
    in_if.valid = 1'b0;
    for (int i = 0; i < 10 && out_if.valid; i++) begin
      got.push_back(out_if.data);
      tick();
    end
    n_checks++;
    if (got.size() !== 5) begin
      n_fail++;
      $display("FAIL full_pop_count got=%0d exp=5", got.size());
    end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL full_pop_order idx%0d got=0x%02h exp=0x%02h", i, got[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_wrap_stream();
    logic [DW-1:0] got [$];
    int            next_beat;
    int            push_start;
    int            cyc;
    next_beat  = 0;
    push_start = n_push;
    cyc        = 0;
    while (got.size() < 20 && cyc < 1000) begin
      in_if.valid  = (next_beat < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
      in_if.data   = DW'(next_beat);
      out_if.ready = 1'($urandom_range(0, 1));
      #1;
      n_checks++;
      if (in_if.ready !== (model_q.size() < DEPTH) || out_if.valid !== (model_q.size() > 0)) begin
        n_fail++;
        $display("FAIL stream_flags cyc%0d got ready=%b valid=%b model_size=%0d",
                 cyc, in_if.ready, out_if.valid, model_q.size());
      end
      n_checks++;
      if (observed_state() !== model_state()) begin
        n_fail++;
        $display("FAIL stream_state cyc%0d got=%s exp=%s", cyc,
                 observed_state().name(), model_state().name());
      end
      if (model_q.size() > 0) begin
        n_checks++;
        if (out_if.data !== model_q[0]) begin
          n_fail++;
          $display("FAIL stream_head cyc%0d got=0x%02h exp=0x%02h", cyc, out_if.data, model_q[0]);
        end
      end
`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
      n_checks++;
      if (fill_level !== 3'(model_q.size()) || fill_level > 3'd4) begin
        n_fail++;
        $display("FAIL stream_fill_level cyc%0d got=%0d exp=%0d", cyc, fill_level, model_q.size());
      end
`endif
      if (out_if.valid && out_if.ready) got.push_back(out_if.data);
      if (in_if.valid && model_q.size() < DEPTH) next_beat++;
      tick();
      cyc++;
    end
    n_checks++;
    if (got.size() !== 20) begin
      n_fail++;
      $display("FAIL stream_timeout received=%0d exp=20 after %0d cycles", got.size(), cyc);
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== DW'(i)) begin
        n_fail++;
        $display("FAIL stream_order idx%0d got=0x%02h exp=0x%02h", i, got[i], DW'(i));
      end
    end
    n_checks++;
    if (n_push - push_start < 4 * DEPTH) begin
      n_fail++;
      $display("FAIL stream_wraps pushes=%0d exp>=%0d", n_push - push_start, 4 * DEPTH);
    end
    in_if.valid  = 1'b0;
    out_if.ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_if.valid = 1'b1;
      in_if.data  = DW'(8'h30 + i);
      tick();
    end
    in_if.data = 8'h33;
    n_checks++;
    if (out_if.valid !== 1'b1) begin
      n_fail++;
      $display("FAIL areset_pre_valid got=%b exp=1", out_if.valid);
    end
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    n_checks++;
    if (out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_valid_immediate got=%b exp=0", out_if.valid);
    end
    n_checks++;
    if (in_if.ready !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_ready_immediate got=%b exp=0", in_if.ready);
    end
`ifdef READY_VALID_FIFO_FILL_LEVEL_EN
    n_checks++;
    if (fill_level !== 3'd0) begin
      n_fail++;
      $display("FAIL areset_fill_level got=%0d exp=0", fill_level);
    end
`endif
    tick();
    tick();
    rst         = 1'b0;
    in_if.valid = 1'b1;
    in_if.data  = 8'h77;
    tick();
    in_if.data  = 8'h78;
    n_checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h77) begin
      n_fail++;
      $display("FAIL areset_clean_head got valid=%b data=0x%02h exp 1/0x77",
               out_if.valid, out_if.data);
    end
    tick();
    in_if.valid  = 1'b0;
    out_if.ready = 1'b1;
    tick();
    n_checks++;
    if (out_if.valid !== 1'b1 || out_if.data !== 8'h78) begin
      n_fail++;
      $display("FAIL areset_clean_second got valid=%b data=0x%02h exp 1/0x78",
               out_if.valid, out_if.data);
    end
    tick();
    n_checks++;
    if (out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_clean_drained got=%b exp=0", out_if.valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_fill_stall();
    test_full_pop();
    test_wrap_stream();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ready_valid_fifo.md
# ready_valid_fifo

Synchronous first-word-fall-through FIFO with ready/valid interfaces on both sides, placed directly upstream of the ready/valid duplicator. It breaks the combinational path from the duplicator's AND-of-all-output-readies back to the producer: `in.ready` depends only on registered state. It also absorbs consumer stalls of up to DEPTH beats without loss.

## Interface
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2; elaboration fails otherwise.
- `DATA_WIDTH`, default 32: width of `in.data` / `out.data`.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in`, `ready_valid_i.s`, DATA_WIDTH: producer side (`data`, `valid` in; `ready` out).
- `out`, `ready_valid_i.m`, DATA_WIDTH: consumer side (`data`, `valid` out; `ready` in), normally feeding a duplicator's `in`.
- `fill_level`, output, $clog2(DEPTH)+1: number of stored entries. Present only with `READY_VALID_FIFO_FILL_LEVEL_EN`.

## Operation
- Storage is a DEPTH-entry register array.
- Pointers `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Index = low $clog2(DEPTH) bits.
  - Pointers increment modulo 2·DEPTH, with natural wrap-around.
- Occupancy states are derived from the pointers, not stored:
  - EMPTY: `wr_ptr == rd_ptr`.
  - FULL: indices are equal and wrap bits differ.
  - PARTIAL: all other cases.
- Push: `in.valid && in.ready`. Writes `in.data` at `wr_ptr` index, then increments `wr_ptr`.
- Pop: `out.valid && out.ready`. Increments `rd_ptr`.
- `in.ready = !FULL && !rst`. It never depends on `out.ready` in the same cycle.
- `out.valid = !EMPTY`.
- `out.data` = entry at `rd_ptr` index. This is FWFT: it is valid whenever `out.valid` is high and is stable while `out.valid && !out.ready`.
- Simultaneous push and pop in PARTIAL: both occur and the count is unchanged.
- In EMPTY: pop is impossible. A push moves the state to PARTIAL.
  - There is no combinational bypass; the data appears on `out` in the following cycle.
- In FULL: push is refused (`in.ready`=0) even if `out.ready`=1 that cycle. A pop moves the state to PARTIAL, and `in.ready` rises the next cycle.
- Beat order is strictly preserved. No data is dropped or duplicated.
- Reset mid-operation discards all stored beats immediately.
  - The partially handshaken beat in that cycle counts as not transferred.
  - The producer must re-present it.

## Timing
- Latency from push to the beat first visible on `out.valid`/`out.data`: 1 cycle, when the FIFO was EMPTY.
- Throughput: 1 beat/cycle sustained in PARTIAL. A DEPTH of at least 2 is required for full rate across a FULL→PARTIAL transition.
- Handshake rules:
  - `out.valid` never deasserts without a pop.
  - `out.data` never changes while valid and not popped.
  - `in.ready` is registered-state-only.
- Reset values (asserted asynchronously, held while `rst`=1):
  - `wr_ptr` = 0, `rd_ptr` = 0.
  - `out.valid` = 0, `in.ready` = 0, `fill_level` = 0.
  - Array contents are not reset; `out.data` is don't-care while invalid.
- After `rst` deasserts: `in.ready` = 1 on the first clock edge.

## Configuration
- `READY_VALID_FIFO_FILL_LEVEL_EN` defined:
  - `fill_level` = `wr_ptr - rd_ptr` (modulo 2·DEPTH, width $clog2(DEPTH)+1), driven combinationally from the pointers.
  - Range 0..DEPTH; it reads DEPTH when FULL.
- Not defined:
  - The port is absent and no subtraction logic is built.
  - All other behaviour is identical.

## Structure
- Shared package `ready_valid_pkg`:
  - `ptr_width(depth)` function returning $clog2(depth)+1.
  - `fifo_state_t` enum {EMPTY, PARTIAL, FULL}, used by the RTL and by bench assertions.
- One natural sub-module: `ready_valid_fifo_ptr`.
  - Holds one pointer register with increment-on-enable and async reset.
  - Instantiated twice, once for write and once for read.

## Test plan
(DEPTH=4, DATA_WIDTH=8.)
- Reset then idle: `rst`=1 for 3 cycles → `out.valid`=0, `in.ready`=0. The cycle after release → `in.ready`=1, `out.valid`=0.
- Single beat: push 0xA5 with `out.ready`=1 → `out.valid`=1 with `out.data`=0xA5 exactly one cycle later, then 0 the next cycle.
- Fill and stall: push 0x01..0x04 with `out.ready`=0 → `in.ready`=0 after the 4th push, and `fill_level`=4. Holding `in.valid` with 0x05 for 5 cycles → no acceptance and `out.data` stays 0x01.
- Full with pop: from FULL, set `out.ready`=1 and `in.valid`=1 (0x05) → 0x01 popped and 0x05 refused that cycle. The next cycle `in.ready`=1 and 0x05 is accepted. The output order is 0x01..0x05.
- Wrap-around streaming: 20 beats 0x00..0x13 with random `in.valid`/`out.ready` (50%) → identical order out, `fill_level` always ≤4, pointers wrap at least twice.
- Async reset mid-stream: assert `rst` between clock edges with 3 stored beats → `out.valid` falls immediately without waiting for a clock edge, and `fill_level`=0. The post-reset stream starts clean.
